// File: rtl/chacha20_block.sv
// chacha20_block: iterative ChaCha block function, one round per clock, feed-forward add on completion.
module chacha20_block #(
    parameter int ROUNDS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] state_in  [16],
    output logic        done,
    output logic [31:0] state_out [16]
);
    localparam int CW = $clog2(ROUNDS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] x_q [16], x_d [16];
    logic [31:0] orig_q [16], orig_d [16];
    logic [31:0] state_out_q [16], state_out_d [16];
    logic [31:0] x_rnd [16];
    logic [127:0] qr_o;

    function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Row r of quarter-round i: columns keep the lane, diagonals shift it by r.
    function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] i, input logic diag);
        return {r, 2'(i + (diag ? r : 2'd0))};
    endfunction

    always_comb begin
        x_rnd = x_q;
        qr_o  = '0;
        for (int i = 0; i < 4; i++) begin
            qr_o = qr(x_q[idx(2'd0, 2'(i), cnt_q[0])], x_q[idx(2'd1, 2'(i), cnt_q[0])],
                      x_q[idx(2'd2, 2'(i), cnt_q[0])], x_q[idx(2'd3, 2'(i), cnt_q[0])]);
            x_rnd[idx(2'd0, 2'(i), cnt_q[0])] = qr_o[127:96];
            x_rnd[idx(2'd1, 2'(i), cnt_q[0])] = qr_o[95:64];
            x_rnd[idx(2'd2, 2'(i), cnt_q[0])] = qr_o[63:32];
            x_rnd[idx(2'd3, 2'(i), cnt_q[0])] = qr_o[31:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        x_d         = x_q;
        orig_d      = orig_q;
        state_out_d = state_out_q;
        if (state_q == IDLE) begin
            if (start) begin
                x_d     = state_in;
                orig_d  = state_in;
                cnt_d   = '0;
                state_d = RUN;
            end
        end else if (cnt_q == CW'(ROUNDS)) begin
            for (int i = 0; i < 16; i++) state_out_d[i] = x_q[i] + orig_q[i];
            done_d  = 1'b1;
            state_d = IDLE;
        end else begin
            x_d   = x_rnd;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                x_q[i]         <= '0;
                orig_q[i]      <= '0;
                state_out_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            x_q         <= x_d;
            orig_q      <= orig_d;
            state_out_q <= state_out_d;
        end
    end

    assign done      = done_q;
    assign state_out = state_out_q;
endmodule

// File: tb/tb_chacha20_block.sv
// tb_chacha20_block: directed scoreboard bench for chacha20_block against RFC vectors and a software model.
module tb_chacha20_block;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] state_in  [16];
    logic [31:0] state_out [16];
    logic        done;

    int total = 0, bad = 0, cyc = 0, dbl = 0, c;
    logic prev_done = 1'b0;
    logic [511:0] exp_q [$];
    int           due_q [$];
    logic [511:0] v25, e25, v29;

    localparam logic [31:0] V25 [16] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    localparam logic [31:0] E25 [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    chacha20_block #(.ROUNDS(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .state_in(state_in), .done(done), .state_out(state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done && prev_done) dbl++;
        prev_done = done;
    end

    function automatic logic [511:0] pack(input logic [31:0] a [16]);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = a[i];
        return r;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qrm(input logic [31:0] a, b, c, d);
        a += b; d = rotl(d ^ a, 16);
        c += d; b = rotl(b ^ c, 12);
        a += b; d = rotl(d ^ a, 8);
        c += d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha(input logic [511:0] s);
        logic [31:0] x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int k = 0; k < 10; k++) begin
            {x[0], x[4], x[8],  x[12]} = qrm(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qrm(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qrm(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qrm(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qrm(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qrm(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qrm(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qrm(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[32*i +: 32];
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; start is sampled on the next rising edge.
    task automatic kick(input logic [511:0] v, input logic [511:0] e, input bit track);
        for (int i = 0; i < 16; i++) state_in[i] = v[32*i +: 32];
        start = 1'b1;
        if (track) begin
            exp_q.push_back(e);
            due_q.push_back(cyc + 22);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        logic [511:0] e = '0;
        int d = -1;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40);
        check({tag, " seen"}, 512'(done), 512'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
        end
        check({tag, " data"}, pack(state_out), e);
        check({tag, " time"}, 512'(cyc), 512'(d));
    endtask

    task automatic idle(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        v25 = pack(V25);
        e25 = pack(E25);
        v29 = v25;
        v29[32*12 +: 32] = 32'h00000002;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) state_in[i] = '0;
        repeat (2) @(negedge clk);
        check("rst done", 512'(done), '0);
        check("rst out", pack(state_out), '0);
        rst_n = 1'b1;
        @(negedge clk);

        kick(v25, e25, 1'b1);
        wait_done("tv");

        kick('0, '0, 1'b1);
        wait_done("zero");

        kick(v25, e25, 1'b1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) state_in[i] = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy");
        idle(30, c);
        check("busy extra done", 512'(c), '0);

        kick(v25, '0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst done", 512'(done), '0);
        check("midrst out", pack(state_out), '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(30, c);
        check("midrst no done", 512'(c), '0);
        check("midrst out held", pack(state_out), '0);

        kick(v25, e25, 1'b1);
        wait_done("after rst");
        kick(v29, chacha(v29), 1'b1);
        wait_done("b2b");

        idle(50, c);
        check("hold no done", 512'(c), '0);
        check("hold out", pack(state_out), chacha(v29));
        check("done width", 512'(dbl), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chacha20_block.md
CHACHA20_BLOCK -- requirements
Module: chacha20_block

Interface
REQ-001 SHALL have parameter ROUNDS, default 20, total rounds; legal values are even and at least 2; latency scales with ROUNDS.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin one block computation.
REQ-005 SHALL have port state_in, input, unpacked array of 16 x 32-bit words, input ChaCha state (words 0..15).
REQ-006 SHALL have port done, output, 1 bit, one-cycle pulse marking state_out valid.
REQ-007 SHALL have port state_out, output, unpacked array of 16 x 32-bit words, registered block function result.

Function
REQ-008 SHALL implement a two-state FSM: IDLE and RUN.
REQ-009 In IDLE, when start=1 at a rising edge, SHALL:
- copy state_in into the working array x[0..15] and into the saved array orig[0..15];
- clear the round counter;
- enter RUN.
REQ-010 In RUN, SHALL perform exactly one round per clock; a round is 4 quarter-rounds computed combinationally in parallel and written back to x.
REQ-011 SHALL perform a column round on rounds 0, 2, 4, ... using index sets (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
REQ-012 SHALL perform a diagonal round on rounds 1, 3, 5, ... using index sets (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
REQ-013 SHALL compute the quarter-round QR(a,b,c,d) in this order:
- a+=b; d^=a; d<<<=16;
- c+=d; b^=c; b<<<=12;
- a+=b; d^=a; d<<<=8;
- c+=d; b^=c; b<<<=7.
All additions are modulo 2^32; <<< is a 32-bit rotate left.
REQ-014 After ROUNDS rounds, on the next edge SHALL:
- write state_out[i] = (x[i] + orig[i]) mod 2^32 for every i;
- set done=1;
- return to IDLE.
REQ-015 Latency: if start is sampled at edge N, done SHALL be high for exactly the cycle following edge N+ROUNDS+1 (edge N+21 for the default).
REQ-016 SHALL hold done high for one cycle only, then low.
REQ-017 SHALL keep state_out stable from its update until the next completion or reset.
REQ-018 SHALL ignore start while in RUN; the computation in progress is not disturbed.
REQ-019 SHALL ignore state_in changes after the start edge, because orig captures the input at start.
REQ-020 SHALL accept a start asserted in the cycle where done=1 (FSM already in IDLE), beginning a new block back-to-back.
REQ-021 SHALL keep start held high continuously restarting a new block on each return to IDLE.

Reset
REQ-022 While rst_n=0, asynchronously, SHALL set:
- FSM to IDLE;
- round counter to 0;
- done to 0;
- state_out, x and orig all to zero words.
REQ-023 When rst_n is asserted mid-computation, SHALL abort the computation with no done pulse.
REQ-024 After rst_n deasserts, SHALL wait for a fresh start.

Verification
REQ-025 Standard test vector:
- Stimulus: state_in = 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000, then a 1-cycle start pulse.
- Response: 21 cycles later, done pulses and state_out = e4e7f110 15593bd1 1fdd0f50 c47120a3 c7f4d1c7 0368c033 9aaa2204 4e6cd4c3 466482d2 09aa9f07 05d7c214 a2028bd9 d19c12b5 b94e16de e883d0cb 4e3c50a2.
REQ-026 All-zero input: state_in all 00000000 plus start -> done after 21 cycles; state_out all 00000000.
REQ-027 Start and input changes while busy:
- Stimulus: start re-pulsed and state_in changed to all-ones at cycles 5 and 10 of REQ-025's run.
- Response: single done at the original time, with the REQ-025 output.
REQ-028 Reset mid-run: rst_n pulsed low at round 10 -> done stays 0 and state_out all zero; a subsequent start with the REQ-025 vector yields the REQ-025 output.
REQ-029 Back-to-back blocks:
- Stimulus: start asserted during the done cycle, with state_in word 12 = 00000002.
- Response: a second done exactly 22 cycles after the first; state_out matches a software ChaCha20 model for that input.
REQ-030 Hold and pulse width: after done, state_out holds for 50 idle cycles; done is never high for 2 consecutive cycles.
